// File: rtl/alu_arbiter.sv
// Round-robin (or fixed-priority with ALU_ARB_FIXED_PRIO_EN) sharing of one registered ALU between two requesters.
// Legal op: accept T, response pulse T+3; illegal op: response pulse T+1. Responses have no backpressure.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_sel,
  input  logic [3:0]  req1_sel,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [63:0] resp0_data,
  output logic [63:0] resp1_data,
  output logic        resp0_err,
  output logic        resp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [63:0] alu_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  sel_q, sel_d;
  logic        id_q, id_d;
  logic [1:0]  rv_q, rv_d, re_q, re_d;
  logic [63:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic        grant, accept;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_sel;
  logic [63:0] result;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant = !req0_valid;
`else
  logic last_q, last_d;
  // On a tie the requester not granted last wins.
  assign grant = (req0_valid && req1_valid) ? !last_q : req1_valid;
`endif

  assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  assign in_a   = grant ? req1_a   : req0_a;
  assign in_b   = grant ? req1_b   : req0_b;
  assign in_sel = grant ? req1_sel : req0_sel;

  // RHi is only meaningful for mul and div; otherwise it is stale.
  assign result = (sel_q == 4'b0011 || sel_q == 4'b0100) ? alu_out : {32'h0, alu_out[31:0]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    id_d    = id_q;
    rv_d    = 2'b00;
    re_d    = 2'b00;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = in_a;
          b_d   = in_b;
          sel_d = in_sel;
          id_d  = grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d = grant;
`endif
          if (in_sel == 4'b0000 || in_sel == 4'b1111) begin
            rv_d[grant] = 1'b1;
            re_d[grant] = 1'b1;
            if (grant) rd1_d = 64'h0;
            else       rd0_d = 64'h0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rv_d[id_q] = 1'b1;
        if (id_q) rd1_d = result;
        else      rd0_d = result;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      sel_q   <= 4'h0;
      id_q    <= 1'b0;
      rv_q    <= 2'b00;
      re_q    <= 2'b00;
      rd0_q   <= 64'h0;
      rd1_q   <= 64'h0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign resp0_valid = rv_q[0];
  assign resp1_valid = rv_q[1];
  assign resp0_err   = re_q[0];
  assign resp1_err   = re_q[1];
  assign resp0_data  = rd0_q;
  assign resp1_data  = rd1_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_sel     = (state_q == ISSUE) ? sel_q : 4'h0;
  assign busy        = (state_q != IDLE);

endmodule
